// File: rtl/jdrosent_edge_event_arbiter_if.sv
// jdrosent_edge_event_arbiter_if
//   Tile I/O bus for the edge event arbiter.
//   io_in[0]   clock          io_in[1]   async active-high reset
//   io_in[5:2] req[3:0]       io_in[6]   enable       io_in[7] clear
//   io_out[0]  pulse          io_out[1]  busy
//   io_out[3:2] grant index   io_out[7:4] pending[3:0]
//   master: drives io_in, observes io_out (tile/testbench side)
//   slave : consumes io_in, drives io_out (arbiter side)
interface jdrosent_edge_event_arbiter_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/jdrosent_edge_event_arbiter.sv
// jdrosent_edge_event_arbiter
//   Captures edges on four asynchronous request lines, latches them as
//   pending events and serialises them round-robin onto one shared output
//   pulse of PULSE_LEN cycles followed by a one-cycle gap.
// Parameters:
//   PULSE_LEN  output pulse width in cycles (1..15)
// Ports:
//   io  slave modport of jdrosent_edge_event_arbiter_if
//       io_in  = {clear, enable, req[3:0], reset, clock}
//       io_out = {pending[3:0], grant index[1:0], busy, pulse}
// Build options:
//   EDGE_ARB_BOTH_EDGES_EN  when defined, both rising and falling request
//                           transitions raise a pending event.
module jdrosent_edge_event_arbiter #(
  parameter int unsigned PULSE_LEN = 4
) (
  jdrosent_edge_event_arbiter_if.slave io
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(PULSE_LEN - 1);

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       en;
  logic       clr;

  assign clk = io.io_in[0];
  assign rst = io.io_in[1];
  assign req = io.io_in[5:2];
  assign en  = io.io_in[6];
  assign clr = io.io_in[7];

  state_e     state_q;
  logic [3:0] s_q;
  logic [3:0] h_q;
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [1:0] rr_q;
  logic [1:0] gidx_q;
  logic [3:0] cnt_q;
  logic       pulse_q;
  logic       busy_q;

  logic [3:0] evt;
  logic       grant_ok;
  logic [1:0] gsel;
  logic [1:0] idx;
  logic       found;
  logic [3:0] gbit;

`ifdef EDGE_ARB_BOTH_EDGES_EN
  assign evt = s_q ^ h_q;
`else
  assign evt = s_q & ~h_q;
`endif

  // First pending line at or after rr, wrapping 3->0.
  always_comb begin
    gsel  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!found && pend_q[idx]) begin
        gsel  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_ok = en & ~clr & (|pend_q) & ((state_q == IDLE) | (state_q == GAP));
    gbit     = grant_ok ? (4'b0001 << gsel) : '0;
    // clear beats a new edge, a new edge beats the grant-clear
    pend_d   = clr ? '0 : ((pend_q & ~gbit) | evt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      h_q     <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s_q    <= req;
      h_q    <= s_q;
      pend_q <= pend_d;
      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            gidx_q  <= gsel;
            rr_q    <= gsel + 2'd1;
            cnt_q   <= CNT_LOAD;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= PULSE;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            pulse_q <= 1'b0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        GAP: begin
          if (grant_ok) begin
            gidx_q  <= gsel;
            rr_q    <= gsel + 2'd1;
            cnt_q   <= CNT_LOAD;
            pulse_q <= 1'b1;
            state_q <= PULSE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io.io_out = {pend_q, gidx_q, busy_q, pulse_q};

endmodule

// File: tb/tb_jdrosent_edge_event_arbiter.sv
module tb_jdrosent_edge_event_arbiter;

  localparam int PL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] req = '0;

  jdrosent_edge_event_arbiter_if io();
  assign io.io_in = {clr, en, req, rst, clk};

  jdrosent_edge_event_arbiter #(.PULSE_LEN(PL)) dut (.io(io));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  // Reference model: edge-numbered timeline. A grant at edge t shows the
  // pulse after edges t..t+PL-1, busy through t+PL, and the next grant may
  // be taken no earlier than edge t+PL+1.
  logic [3:0] m_pend, m_s1, m_s2;
  int         m_rr, m_gidx, m_last, m_free, m_n;
  bit         m_ever;

  task automatic model_reset();
    m_pend = '0; m_s1 = '0; m_s2 = '0;
    m_rr = 0; m_gidx = 0; m_last = 0; m_free = 0; m_ever = 0;
  endtask

  task automatic model_edge();
    logic [3:0] ev, gbit;
    int g;
    m_n++;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef EDGE_ARB_BOTH_EDGES_EN
    ev = m_s1 ^ m_s2;
`else
    ev = m_s1 & ~m_s2;
`endif
    gbit = '0;
    if (m_n >= m_free && en && !clr && m_pend != 0) begin
      g = -1;
      for (int i = 0; i < 4; i++)
        if (g < 0 && m_pend[(m_rr + i) % 4]) g = (m_rr + i) % 4;
      gbit[g] = 1'b1;
      m_gidx = g;
      m_rr = (g + 1) % 4;
      m_last = m_n;
      m_free = m_n + PL + 1;
      m_ever = 1;
    end
    m_pend = clr ? 4'b0 : ((m_pend & ~gbit) | ev);
    m_s2 = m_s1;
    m_s1 = req;
  endtask

  function automatic logic [7:0] model_out();
    logic p, b;
    p = m_ever && (m_n - m_last) < PL;
    b = m_ever && (m_n - m_last) <= PL;
    return {m_pend, 2'(m_gidx), b, p};
  endfunction

  int   rises = 0;
  logic prev_pulse = 1'b0;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (io.io_out[0] && !prev_pulse) rises++;
    prev_pulse = io.io_out[0];
  endtask

  task automatic check_model(input string name);
    chk(name, io.io_out, model_out());
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; en = 1'b1; clr = 1'b0;
    step(); step();
    rst = 1'b0;
    prev_pulse = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];
  int   ord[4];
  int   rise_cyc[4];
  int   nr;

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    m_n = 0;
    model_reset();

    // single event on line 2, held high through the table
    tbl[0] = '{4'b0100, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{4'b0100, 1'b1, 1'b0, 8'h40};
    tbl[2] = '{4'b0100, 1'b1, 1'b0, 8'h0B};
    tbl[3] = '{4'b0100, 1'b1, 1'b0, 8'h0B};
    tbl[4] = '{4'b0100, 1'b1, 1'b0, 8'h0B};
    tbl[5] = '{4'b0100, 1'b1, 1'b0, 8'h0B};
    tbl[6] = '{4'b0100, 1'b1, 1'b0, 8'h0A};
    tbl[7] = '{4'b0100, 1'b1, 1'b0, 8'h08};
    tbl[8] = '{4'b0100, 1'b1, 1'b0, 8'h08};

    do_reset();
    chk("reset_state", io.io_out, 8'h00);
    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req; en = tbl[i].en; clr = tbl[i].clr;
      step();
      chk($sformatf("table_row%0d", i), io.io_out, tbl[i].exp);
    end

    // simultaneous events: order 0,1,2,3, spacing PL+1
    do_reset();
    rises = 0; nr = 0;
    req = 4'hF;
    for (int c = 0; c < 30; c++) begin
      step();
      check_model("simul_cycle");
      if (rises > nr && nr < 4) begin
        ord[nr] = int'(io.io_out[3:2]);
        rise_cyc[nr] = c;
        nr = rises;
      end
    end
    chk("simul_grants", 8'(rises), 8'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("simul_order%0d", i), 8'(ord[i]), 8'(i));
    for (int i = 1; i < 4; i++)
      chk($sformatf("simul_spacing%0d", i), 8'(rise_cyc[i] - rise_cyc[i-1]), 8'(PL + 1));

    // enable gating, then clear during a pulse
    do_reset();
    en = 1'b0; req = 4'b0011;
    for (int c = 0; c < 6; c++) step();
    chk("enable_low_hold", io.io_out, 8'h30);
    en = 1'b1;
    step();
    chk("enable_grant0", io.io_out, 8'h23);
    clr = 1'b1;
    step();
    chk("clear_mid_pulse", io.io_out, 8'h03);
    clr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check_model("after_clear");
    end
    chk("after_clear_idle", io.io_out, 8'h00);

    // asynchronous reset during pulse cycle 2, req[0] held through release
    do_reset();
    req = 4'b0001;
    step(); step(); step(); step();
    chk("pulse_before_reset", io.io_out, 8'h03);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", io.io_out, 8'h00);
    model_reset();
    prev_pulse = 1'b0;
    step(); step();
    rst = 1'b0;
    rises = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      check_model("held_release");
    end
    chk("held_release_grants", 8'(rises), 8'd1);

    // high-then-low on req[0]
    do_reset();
    rises = 0;
    req = 4'b0001;
    step(); step(); step();
    req = 4'b0000;
    for (int c = 0; c < 25; c++) begin
      step();
      check_model("pulse_edges");
    end
`ifdef EDGE_ARB_BOTH_EDGES_EN
    chk("pulse_edges_grants", 8'(rises), 8'd2);
`else
    chk("pulse_edges_grants", 8'(rises), 8'd1);
`endif

    // randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      step();
      check_model("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jdrosent_edge_event_arbiter.md
# jdrosent_edge_event_arbiter

Captures rising edges on four asynchronous event lines and serialises them onto one shared, fixed-width output pulse, with round-robin fairness between lines. It sits in front of the team's single-flop rising-edge detector datapath. It replicates that detector per line, adds per-line pending latches and a scheduler, and drives the tile's 8-bit output bus.

## Interface
Parameters:
- PULSE_LEN, 4: width of each granted output pulse in clock cycles; legal range 1..15; 4-bit counter.

Ports (tile convention: control bits live on the io bus):
- io_in[0]  input  1  clock; all state updates on its rising edge
- io_in[1]  input  1  reset; asynchronous, active-high
- io_in[5:2]  input  4  event request lines req[3:0]; req[0] = io_in[2]; asynchronous to clock
- io_in[6]  input  1  enable; low blocks new grants
- io_in[7]  input  1  clear; synchronous, drops all pending events
- io_out[0]  output  1  pulse; shared output pulse
- io_out[1]  output  1  busy; high when the FSM is not in IDLE
- io_out[3:2]  output  2  grant index; current or last granted line
- io_out[7:4]  output  4  pending[3:0]

## Operation
- Per line k:
  - sample register s[k] <= req[k].
  - history register h[k] <= s[k].
  - edge[k] = s[k] & ~h[k].
- Pending latch:
  - pending[k] sets on edge[k].
  - It clears when line k is granted or when clear is high.
  - Precedence: clear > set > grant-clear. An edge in the cycle line k is granted re-sets pending[k].
  - An edge while pending[k] is already set is merged, not counted.
- Round-robin pointer rr (2 bits): the search starts at rr and wraps 3->0. On a grant to line g, rr <= g+1 mod 4.
- FSM states:
  - IDLE:
    - If enable=1, clear=0 and any pending bit is set, grant the first pending line from rr.
    - On a grant: load grant index, clear that pending bit, cnt <= PULSE_LEN-1, go to PULSE.
  - PULSE:
    - pulse=1.
    - When cnt=0, go to GAP; otherwise decrement cnt.
  - GAP:
    - pulse=0 for exactly one cycle.
    - If the IDLE grant condition holds, grant directly into PULSE.
    - Otherwise go to IDLE.
- Enable and clear only gate new grants. A pulse in progress always completes its full PULSE_LEN cycles.
- Reset values:
  - Outputs: pulse=0, busy=0, grant index=0, pending=0.
  - Internal: state IDLE, rr=0, s=h=0.
  - A line held high across reset release therefore yields one event.
- Reset asserted mid-pulse forces pulse=0 immediately (asynchronous) and discards all pending events.

## Timing
- Latency, measured from the first clock edge E at which req[k]=1 is sampled:
  - pending[k] is high after edge E+1.
  - The grant is taken at edge E+2, so pulse and busy go high after E+2 when the FSM is IDLE and enabled.
- The pulse is high for exactly PULSE_LEN cycles, then low for at least 1 cycle.
- Back-to-back grants have a pulse rising-edge spacing of PULSE_LEN+1 cycles.
- An edge on req[k] is guaranteed to be captured only if req[k] is high for at least 1 full clock period and then low for at least 1 full clock period.
- busy is high from the grant edge until the GAP->IDLE transition.
- All outputs are registered, with no combinational path from io_in to io_out. The exception is io_out[0]/io_out[1] clearing on asynchronous reset.

## Configuration
- EDGE_ARB_BOTH_EDGES_EN:
  - Defined: edge[k] = s[k] ^ h[k], so both rising and falling transitions raise pending.
  - Undefined: rising edges only.
- The FSM, arbitration and timing are identical in both builds.

## Test plan
All scenarios use PULSE_LEN=4 and enable=1 unless stated.
- Single event: pulse req[2] high for 3 cycles -> pending=0100 after E+1; pulse high 4 cycles from E+2; grant index=2; pending=0000; busy drops after the GAP.
- Simultaneous events: req[3:0] rise in the same cycle with rr=0 -> grants in order 0,1,2,3; pulse rising edges 5 cycles apart; rr=0 at end.
- Merge and re-pend:
  - Two edges on req[1] during another line's pulse yield one grant.
  - An edge on req[1] during its own grant cycle yields a second grant.
- Enable/clear:
  - enable=0 with pending=0011 -> no pulse; pending holds; raising enable starts grant 0.
  - clear=1 mid-pulse -> the current pulse completes 4 cycles, then pending=0000.
- Reset mid-pulse:
  - Assert reset in pulse cycle 2 -> pulse=0 without waiting for a clock edge; all outputs 0.
  - With req[0] held high through release -> exactly one grant.
- EDGE_ARB_BOTH_EDGES_EN defined: a high-then-low pulse on req[0] -> two grants; undefined -> one grant.
